// File: rtl/tips_seq_ctrl_if.sv
// Banner/press bus between the game-phase sequencer and its neighbours:
// frame/press/game-over inputs in, banner enables, filtered press and phase pulses out.
interface tips_seq_ctrl_if;
    logic       frame_tick;
    logic       press;
    logic       game_over;
    logic       tips_display;
    logic       tips_display_over;
    logic       press_out;
    logic       start_pulse;
    logic       restart_pulse;
    logic [1:0] phase;

    modport master (
        output frame_tick,
        output press,
        output game_over,
        input  tips_display,
        input  tips_display_over,
        input  press_out,
        input  start_pulse,
        input  restart_pulse,
        input  phase
    );

    modport slave (
        input  frame_tick,
        input  press,
        input  game_over,
        output tips_display,
        output tips_display_over,
        output press_out,
        output start_pulse,
        output restart_pulse,
        output phase
    );
endinterface

// File: rtl/tips_seq_ctrl.sv
// Game-phase sequencer (IDLE/PLAY/OVER): hint banners, filtered trail press, start/restart pulses.
// Define TIPS_SEQ_BLINK_EN to make the banners blink; otherwise they are steady.
module tips_seq_ctrl #(
    parameter int unsigned BLINK_FRAMES   = 30,
    parameter int unsigned LOCKOUT_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset_n,
    tips_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic [7:0] LOCK_MAX = 8'(LOCKOUT_FRAMES);

    state_t     state_q, state_nx;
    logic [7:0] lock_q, lock_nx;
    logic       trans;
    logic       blink_ph_nx;

    logic td_q, td_nx;
    logic tdo_q, tdo_nx;
    logic pout_q, pout_nx;
    logic start_q, start_nx;
    logic restart_q, restart_nx;

    always_comb begin : fsm_next
        state_nx   = state_q;
        pout_nx    = 1'b0;
        start_nx   = 1'b0;
        restart_nx = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The starting press is consumed here and never reaches the trail.
                if (bus.press) begin
                    state_nx = PLAY;
                    start_nx = 1'b1;
                end
            end
            PLAY: begin
                if (bus.game_over) begin
                    state_nx = OVER;
                end else if (bus.press) begin
                    pout_nx = 1'b1;
                end
            end
            OVER: begin
                if (bus.press && (lock_q == LOCK_MAX)) begin
                    state_nx   = IDLE;
                    restart_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign trans = (state_nx != state_q);

    always_comb begin : lock_next
        lock_nx = lock_q;
        if (trans) begin
            lock_nx = '0;
        end else if ((state_q == OVER) && bus.frame_tick && (lock_q < LOCK_MAX)) begin
            lock_nx = lock_q + 8'd1;
        end
    end

`ifdef TIPS_SEQ_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt, blink_cnt_nx;
    logic       blink_ph;

    // A state change restarts the blink phase, swallowing any tick in that cycle.
    always_comb begin : blink_next
        blink_cnt_nx = blink_cnt;
        blink_ph_nx  = blink_ph;
        if (trans) begin
            blink_cnt_nx = '0;
            blink_ph_nx  = 1'b1;
        end else if (bus.frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                blink_ph_nx  = ~blink_ph;
            end else begin
                blink_cnt_nx = blink_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nx;
            blink_ph  <= blink_ph_nx;
        end
    end
`else
    assign blink_ph_nx = 1'b1;
`endif

    // Banners are registered from the next state so they line up with phase.
    assign td_nx  = (state_nx == IDLE) && blink_ph_nx;
    assign tdo_nx = (state_nx == OVER) && blink_ph_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lock_q    <= '0;
            td_q      <= 1'b1;
            tdo_q     <= 1'b0;
            pout_q    <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            lock_q    <= lock_nx;
            td_q      <= td_nx;
            tdo_q     <= tdo_nx;
            pout_q    <= pout_nx;
            start_q   <= start_nx;
            restart_q <= restart_nx;
        end
    end

    assign bus.phase             = state_q;
    assign bus.tips_display      = td_q;
    assign bus.tips_display_over = tdo_q;
    assign bus.press_out         = pout_q;
    assign bus.start_pulse       = start_q;
    assign bus.restart_pulse     = restart_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (BLINK_FRAMES >= 1 && BLINK_FRAMES <= 255);
            assert (LOCKOUT_FRAMES >= 1 && LOCKOUT_FRAMES <= 255);
            assert ($onehot0({pout_q, start_q, restart_q}));
            assert (state_q != 2'b11);
        end
    end
`endif

endmodule

// File: tb/tb_tips_seq_ctrl.sv
// Scoreboard bench for tips_seq_ctrl with BLINK_FRAMES=2, LOCKOUT_FRAMES=3.
// Expectations adapt to whether TIPS_SEQ_BLINK_EN is defined.
module tb_tips_seq_ctrl;

    localparam logic [1:0] P_IDLE = 2'b00;
    localparam logic [1:0] P_PLAY = 2'b01;
    localparam logic [1:0] P_OVER = 2'b10;

`ifdef TIPS_SEQ_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] phase;
        logic       td;
        logic       tdo;
        logic       pout;
        logic       start;
        logic       restart;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    tips_seq_ctrl_if bus ();

    tips_seq_ctrl #(
        .BLINK_FRAMES   (2),
        .LOCKOUT_FRAMES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic obs_t mk(input logic [1:0] ph, input logic td, input logic tdo,
                                input logic pout, input logic st, input logic rs);
        obs_t o;
        o.phase   = ph;
        o.td      = td;
        o.tdo     = tdo;
        o.pout    = pout;
        o.start   = st;
        o.restart = rs;
        return o;
    endfunction

    // Banner phase after k ticks since the last state change, with a 2-frame half-period.
    function automatic logic ph_after(input int k);
        if (!BLINK) return 1'b1;
        return ((k / 2) % 2) == 0;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input obs_t e);
        check_val({tag, ".phase"},   8'(bus.phase),             8'(e.phase));
        check_val({tag, ".td"},      8'(bus.tips_display),      8'(e.td));
        check_val({tag, ".tdo"},     8'(bus.tips_display_over), 8'(e.tdo));
        check_val({tag, ".pout"},    8'(bus.press_out),         8'(e.pout));
        check_val({tag, ".start"},   8'(bus.start_pulse),       8'(e.start));
        check_val({tag, ".restart"}, 8'(bus.restart_pulse),     8'(e.restart));
    endtask

    task automatic step(input string tag, input logic ft, input logic pr, input logic go, input obs_t e);
        bus.frame_tick = ft;
        bus.press      = pr;
        bus.game_over  = go;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.press      = 1'b0;
        check_outputs(tag_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.press      = 1'b0;
        bus.game_over  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_outputs("reset_hold", mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b1;

        // IDLE blink, with a no-tick cycle and a game_over that must be ignored
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("idle_tick%0d", k), 1'b1, 1'b0, 1'b0,
                 mk(P_IDLE, ph_after(k), 1'b0, 1'b0, 1'b0, 1'b0));
            if (k == 2)
                step("idle_hold", 1'b0, 1'b0, 1'b1, mk(P_IDLE, ph_after(2), 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // Start with a coincident tick: transition wins
        step("start", 1'b1, 1'b1, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("play_settle", 1'b0, 1'b0, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 3; i++) begin
            step($sformatf("play_press%0d", i), (i == 1), 1'b1, 1'b0,
                 mk(P_PLAY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int j = 0; j < 3; j++)
                step($sformatf("play_gap%0d_%0d", i, j), 1'b0, 1'b0, 1'b0,
                     mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // game_over beats press; game_over then stays high in OVER
        step("over_entry", 1'b0, 1'b1, 1'b1, mk(P_OVER, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("over_t1", 1'b1, 1'b0, 1'b1, mk(P_OVER, 1'b0, ph_after(1), 1'b0, 1'b0, 1'b0));
        step("over_t2", 1'b1, 1'b0, 1'b1, mk(P_OVER, 1'b0, ph_after(2), 1'b0, 1'b0, 1'b0));
        step("over_locked", 1'b0, 1'b1, 1'b1, mk(P_OVER, 1'b0, ph_after(2), 1'b0, 1'b0, 1'b0));
        step("over_t3_press", 1'b1, 1'b1, 1'b1, mk(P_OVER, 1'b0, ph_after(3), 1'b0, 1'b0, 1'b0));
        step("restart", 1'b0, 1'b1, 1'b0, mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        step("idle_after", 1'b0, 1'b0, 1'b0, mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Second round: lockout counter saturates past the threshold
        step("start2", 1'b0, 1'b1, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("over2", 1'b0, 1'b0, 1'b1, mk(P_OVER, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++)
            step($sformatf("over2_tick%0d", k), 1'b1, 1'b0, 1'b0,
                 mk(P_OVER, 1'b0, ph_after(k), 1'b0, 1'b0, 1'b0));
        step("restart2", 1'b0, 1'b1, 1'b0, mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

        for (int k = 1; k <= 100; k++)
            step($sformatf("idle_long%0d", k), 1'b1, 1'b0, 1'b0,
                 mk(P_IDLE, ph_after(k), 1'b0, 1'b0, 1'b0, 1'b0));

        // Asynchronous reset between edges while press_out is high
        step("start3", 1'b0, 1'b1, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("play3_press", 1'b0, 1'b1, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_outputs("async_rst_hold", mk(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b1;
        step("start4", 1'b0, 1'b1, 1'b0, mk(P_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
